// File: rtl/serial_to_parallel_framer.sv
// Framed serial-to-parallel collector with valid/ready output and sticky overrun flag.
// Optional even-parity bit per frame when PARITY_CHECK_EN is defined.
module serial_to_parallel_framer #(
  parameter int W         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ser_in,
  input  logic         ser_valid,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         overrun,
  input  logic         clr_ovr,
  output logic         parity_err
);

  localparam int CNT_W = $clog2(W) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
`ifdef PARITY_CHECK_EN
    S_PARITY,
`endif
    S_HOLD
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [W-1:0]     r_shift, w_shift_nxt, w_shift_in;
  logic [CNT_W-1:0] r_bit_cnt, w_cnt_nxt;
  logic [W-1:0]     r_out_data, w_data_nxt;
  logic             r_out_valid, w_valid_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_overrun, w_ovr_set;
  logic             w_last_bit;
`ifdef PARITY_CHECK_EN
  logic             r_parity_err, w_perr_nxt;
`endif

  always_comb begin
    w_shift_in = '0;
    if (MSB_FIRST) w_shift_in = {r_shift[W-2:0], ser_in};
    else           w_shift_in = {ser_in, r_shift[W-1:1]};
  end

  assign w_last_bit = (r_bit_cnt == CNT_W'(W - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_bit_cnt;
    w_data_nxt  = r_out_data;
    w_valid_nxt = r_out_valid;
    w_ovr_set   = 1'b0;
`ifdef PARITY_CHECK_EN
    w_perr_nxt  = r_parity_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (ser_valid && ser_in) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
          w_shift_nxt = '0;
        end
      end
      S_SHIFT: begin
        if (ser_valid) begin
          w_shift_nxt = w_shift_in;
          w_cnt_nxt   = r_bit_cnt + CNT_W'(1);
          if (w_last_bit) begin
`ifdef PARITY_CHECK_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_HOLD;
            w_data_nxt  = w_shift_in;
            w_valid_nxt = 1'b1;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      S_PARITY: begin
        if (ser_valid) begin
          w_state_nxt = S_HOLD;
          w_data_nxt  = r_shift;
          w_valid_nxt = 1'b1;
          w_perr_nxt  = ^{r_shift, ser_in};
        end
      end
`endif
      S_HOLD: begin
        if (out_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
        // A start bit coinciding with the transfer begins the next frame; any other strobe here is lost.
        if (ser_valid) begin
          if (out_ready && ser_in) begin
            w_state_nxt = S_SHIFT;
            w_cnt_nxt   = '0;
            w_shift_nxt = '0;
          end else begin
            w_ovr_set = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt = (w_state_nxt == S_SHIFT);
`ifdef PARITY_CHECK_EN
    if (w_state_nxt == S_PARITY) w_busy_nxt = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_cnt_nxt;
      r_out_data  <= w_data_nxt;
      r_out_valid <= w_valid_nxt;
      r_busy      <= w_busy_nxt;
      if (w_ovr_set)    r_overrun <= 1'b1;
      else if (clr_ovr) r_overrun <= 1'b0;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_parity_err <= 1'b0;
    else        r_parity_err <= w_perr_nxt;
  end
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_serial_to_parallel_framer.sv
// Scoreboard bench driving an MSB-first and an LSB-first framer from one serial stream.
module tb_serial_to_parallel_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ser_in = 1'b0, ser_valid = 1'b0, out_ready = 1'b1, clr_ovr = 1'b0;
  logic [3:0] data_m, data_l;
  logic       vld_m, vld_l, busy_m, busy_l, ovr_m, ovr_l, perr_m, perr_l;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] dm;
    logic [3:0] dl;
    logic       pe;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_to_parallel_framer #(.W(4), .MSB_FIRST(1'b1)) u_dut_m (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
    .out_data(data_m), .out_valid(vld_m), .out_ready(out_ready), .busy(busy_m),
    .overrun(ovr_m), .clr_ovr(clr_ovr), .parity_err(perr_m)
  );

  serial_to_parallel_framer #(.W(4), .MSB_FIRST(1'b0)) u_dut_l (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
    .out_data(data_l), .out_valid(vld_l), .out_ready(out_ready), .busy(busy_l),
    .overrun(ovr_l), .clr_ovr(clr_ovr), .parity_err(perr_l)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: a word is checked on the cycle it is handed downstream.
  always @(negedge clk) begin
    if (rst_n && (vld_m || vld_l)) begin
      chk("vld_match", {31'd0, vld_l}, {31'd0, vld_m});
      if (out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("data_msb", {28'd0, data_m}, {28'd0, e.dm});
          chk("data_lsb", {28'd0, data_l}, {28'd0, e.dl});
          chk("perr_msb", {31'd0, perr_m}, {31'd0, e.pe});
          chk("perr_lsb", {31'd0, perr_l}, {31'd0, e.pe});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic b);
    ser_valid = 1'b1;
    ser_in    = b;
    tick();
    ser_valid = 1'b0;
    ser_in    = 1'b0;
  endtask

  function automatic exp_t mk_exp(input logic [3:0] seq, input logic par);
    exp_t e;
    e.dm = seq;
    e.dl = {seq[0], seq[1], seq[2], seq[3]};
`ifdef PARITY_CHECK_EN
    e.pe = (^seq) ^ par;
`else
    e.pe = 1'b0;
`endif
    return e;
  endfunction

  // seq[3] is the first data bit on the line; start bit optional for the HOLD-restart case.
  task automatic send_body(input logic [3:0] seq, input int gap, input logic par);
    sb.push_back(mk_exp(seq, par));
    for (int i = 3; i >= 0; i--) begin
      strobe(seq[i]);
      if (i != 0) idle(gap);
    end
`ifdef PARITY_CHECK_EN
    chk("busy_parity", {31'd0, busy_m}, 32'd1);
    idle(gap);
    strobe(par);
`endif
    chk("valid_latency", {31'd0, vld_m}, 32'd1);
    chk("busy_hold", {31'd0, busy_m}, 32'd0);
  endtask

  task automatic send_frame(input logic [3:0] seq, input int gap, input logic par);
    strobe(1'b1);
    chk("busy_shift", {31'd0, busy_m}, 32'd1);
    idle(gap);
    send_body(seq, gap, par);
  endtask

  initial begin
    idle(2);
    chk("rst_valid", {31'd0, vld_m}, 32'd0);
    chk("rst_data", {28'd0, data_m}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Line idle: zero strobes in IDLE are ignored.
    strobe(1'b0);
    strobe(1'b0);
    chk("idle_ignore_busy", {31'd0, busy_m}, 32'd0);
    chk("idle_ignore_ovr", {31'd0, ovr_m}, 32'd0);

    // Reset mid-frame after two data bits.
    strobe(1'b1);
    strobe(1'b1);
    strobe(1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy_m | busy_l}, 32'd0);
    chk("rst_mid_valid", {31'd0, vld_m | vld_l}, 32'd0);
    chk("rst_mid_data", {28'd0, data_m | data_l}, 32'd0);
    chk("rst_mid_flags", {30'd0, ovr_m | ovr_l, perr_m | perr_l}, 32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    send_frame(4'b1100, 0, 1'b0);

    // Basic frame, single-cycle valid with ready held high.
    send_frame(4'b1011, 0, 1'b1);
    tick();
    chk("valid_one_cycle", {31'd0, vld_m}, 32'd0);
    chk("basic_ovr", {31'd0, ovr_m}, 32'd0);

    // Same frame with idle gaps between strobes, plus a parity-error variant.
    send_frame(4'b1011, 3, 1'b1);
    idle(1);
    send_frame(4'b1011, 1, 1'b0);
    idle(1);

    // Backpressure: word held for 5 cycles, then released.
    out_ready = 1'b0;
    send_frame(4'b0110, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'd0, vld_m}, 32'd1);
      chk("bp_data", {28'd0, data_m}, 32'h6);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", {31'd0, vld_m}, 32'd0);
    chk("bp_release_busy", {31'd0, busy_m}, 32'd0);

    // Overrun: strobe in HOLD sets sticky flag, word untouched.
    out_ready = 1'b0;
    send_frame(4'b1001, 0, 1'b0);
    strobe(1'b0);
    chk("ovr_set", {31'd0, ovr_m}, 32'd1);
    chk("ovr_data", {28'd0, data_m}, 32'h9);
    chk("ovr_valid", {31'd0, vld_m}, 32'd1);
    idle(2);
    chk("ovr_sticky", {31'd0, ovr_l}, 32'd1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_clear", {31'd0, ovr_m}, 32'd0);
    clr_ovr = 1'b1;
    strobe(1'b1);
    clr_ovr = 1'b0;
    chk("ovr_set_wins", {31'd0, ovr_m}, 32'd1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_clear2", {31'd0, ovr_m}, 32'd0);

    // Transfer and start bit in the same cycle.
    out_ready = 1'b1;
    strobe(1'b1);
    chk("simul_busy", {31'd0, busy_m}, 32'd1);
    chk("simul_valid", {31'd0, vld_m}, 32'd0);
    chk("simul_ovr", {31'd0, ovr_m}, 32'd0);
    send_body(4'b0111, 0, 1'b1);
    idle(3);
    chk("final_ovr", {31'd0, ovr_m | ovr_l}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
